// File: rtl/imem_boot_pkg.sv
// rtl/imem_boot_pkg.sv - shared types and constants for the imem boot-load sequencer
// Contents:
//   state_t    sequencer states (IDLE, LOAD, DRAIN, RUN, ERR)
//   DEPTH_DEF  default imem depth in 32-bit words
//   RLS_CNT_W  width of the drain (release delay) counter, covers 1..15
package imem_boot_pkg;

    localparam int DEPTH_DEF = 1024;
    localparam int RLS_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/imem_boot_csum.sv
// rtl/imem_boot_csum.sv - 32-bit wrap-around image checksum accumulator
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      zero the running sum (start of a new load)
//   add        accumulate add_data this cycle
//   add_data   word being written to imem
//   cmp_data   checksum word presented by the loader
//   match      running sum (excluding this cycle's add) equals cmp_data
module imem_boot_csum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        add,
    input  logic [31:0] add_data,
    input  logic [31:0] cmp_data,
    output logic        match
);

    logic [31:0] sum;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + add_data;
        end
    end

    assign match = (sum == cmp_data);

endmodule

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - boot-load sequencer: loader word stream to imem, then core reset release
// Optional feature macro: CHECKSUM_EN (last word is a checksum; mismatch or overflow -> ERR)
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   boot_start           1-cycle pulse, start or restart a load
//   ld_valid/ld_data/ld_last/ld_ready   loader word stream handshake
//   imem_we/imem_waddr/imem_wdata       registered imem write port
//   core_rst_n           core reset, held low until the image is loaded and drained
//   boot_done            core running a loaded image
//   boot_err             load failed (CHECKSUM_EN only, else 0)
//   word_count           words written by the current/last load
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int ADDR_W      = 10,
    parameter int RELEASE_DLY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_start,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              boot_done,
    output logic              boot_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0]    FULL_CNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [RLS_CNT_W-1:0] DLY_LAST = RLS_CNT_W'(RELEASE_DLY - 1);

    state_t               state, state_n;
    logic [ADDR_W:0]      cnt;
    logic [RLS_CNT_W-1:0] dcnt;
    logic                 hs;
    logic                 wr;
    logic                 at_full;

    // A restart in the same cycle as a handshake drops the word.
    assign hs      = ld_valid & (state == LOAD) & ~boot_start;
    assign at_full = (cnt == FULL_CNT);

`ifdef CHECKSUM_EN
    logic csum_ok;

    // The ld_last word is the checksum and never reaches imem.
    assign wr = hs & ~ld_last;

    imem_boot_csum u_csum (
        .clk      (clk),
        .rst      (rst),
        .clear    (boot_start),
        .add      (wr),
        .add_data (ld_data),
        .cmp_data (ld_data),
        .match    (csum_ok)
    );
`else
    assign wr = hs;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        ld_ready   = (state == LOAD);
        core_rst_n = (state == RUN);
        boot_done  = (state == RUN);
        boot_err   = 1'b0;
`ifdef CHECKSUM_EN
        boot_err   = (state == ERR);
`endif
        if (boot_start) begin
            state_n = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (hs) begin
`ifdef CHECKSUM_EN
                        if (ld_last) begin
                            state_n = csum_ok ? DRAIN : ERR;
                        end else if (at_full) begin
                            state_n = ERR;
                        end
`else
                        if (ld_last || at_full) begin
                            state_n = DRAIN;
                        end
`endif
                    end
                end
                DRAIN: begin
                    if (dcnt == DLY_LAST) begin
                        state_n = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write port is registered: the word lands one cycle after its handshake,
    // and an already-registered write still completes across a restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            dcnt       <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= wr;
            if (wr) begin
                imem_waddr <= cnt[ADDR_W-1:0];
                imem_wdata <= ld_data;
            end
            if (boot_start) begin
                cnt <= '0;
            end else if (wr) begin
                cnt <= cnt + (ADDR_W+1)'(1);
            end
            if (state != DRAIN) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + RLS_CNT_W'(1);
            end
        end
    end

    assign word_count = cnt;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - randomized scoreboard bench for imem_boot_ctrl
module tb_imem_boot_ctrl;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DLY    = 4;
`ifdef CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              boot_start = 1'b0;
    logic              ld_valid = 1'b0;
    logic [31:0]       ld_data = '0;
    logic              ld_last = 1'b0;
    logic              ld_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              boot_done;
    logic              boot_err;
    logic [ADDR_W:0]   word_count;

    imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RELEASE_DLY(DLY)) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_start (boot_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .boot_done  (boot_done),
        .boot_err   (boot_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    int          vectors = 0;
    int          errors  = 0;

    // Reference model: what the loader has been promised so far.
    bit          m_loading = 1'b0;
    int          m_count   = 0;
    logic [31:0] m_sum     = '0;
    int          m_end     = 0;   // 0 still loading, 1 image accepted, 2 load failed

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected no write at %0t",
                         imem_waddr, imem_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(imem_waddr), 64'(e.addr));
                chk("write_data", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    task automatic model_word(input logic [31:0] d, input bit last);
        wr_t w;
        if (!m_loading) return;
        if (CSUM && last) begin
            m_loading = 1'b0;
            m_end     = (d == m_sum) ? 1 : 2;
        end else begin
            w.addr = m_count[ADDR_W-1:0];
            w.data = d;
            exp_q.push_back(w);
            m_count++;
            m_sum = m_sum + d;
            if (last || m_count == DEPTH) begin
                m_loading = 1'b0;
                m_end     = (CSUM && !last) ? 2 : 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input bit last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(negedge clk);
        chk("ld_ready", 64'(ld_ready), 64'(m_loading));
        model_word(d, last);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = $urandom;
    endtask

    task automatic do_start(input bit with_word);
        boot_start = 1'b1;
        if (with_word) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            ld_last  = 1'b0;
        end
        @(posedge clk);
        #1;
        boot_start = 1'b0;
        ld_valid   = 1'b0;
        m_loading  = 1'b1;
        m_count    = 0;
        m_sum      = '0;
        m_end      = 0;
        @(negedge clk);
        chk("start_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("start_boot_done", 64'(boot_done), 64'd0);
        chk("start_boot_err", 64'(boot_err), 64'd0);
        chk("start_word_count", 64'(word_count), 64'd0);
        chk("start_ld_ready", 64'(ld_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Called right after the edge that accepted the final word of a load.
    task automatic check_end();
        for (int k = 1; k <= DLY + 1; k++) begin
            @(negedge clk);
            if (k == 1) chk("word_count", 64'(word_count), 64'(m_count));
            chk("end_ld_ready", 64'(ld_ready), 64'd0);
            if (m_end == 1) begin
                chk("core_rst_n", 64'(core_rst_n), 64'(k > DLY));
                chk("boot_done", 64'(boot_done), 64'(k > DLY));
            end else begin
                chk("err_boot_err", 64'(boot_err), 64'd1);
                chk("err_core_rst_n", 64'(core_rst_n), 64'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input int n, input bit use_last, input bit gap, input bit bad);
        bit          ended;
        bit          last;
        logic [31:0] d;
        ended = 1'b0;
        for (int i = 0; i < n; i++) begin
            last = use_last && (i == n - 1);
            d    = $urandom;
            if (CSUM && last) d = m_sum + 32'(bad);
            send_word(d, last);
            if (m_end != 0 && !ended) begin
                ended = 1'b1;
                check_end();
            end
            if (gap && !ended) idle(2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bit partial;

        // Reset for three cycles, then IDLE ignores the loader.
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_imem_waddr", 64'(imem_waddr), 64'd0);
        chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("rst_boot_done", 64'(boot_done), 64'd0);
        chk("rst_boot_err", 64'(boot_err), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);

        // Back-to-back three-word image.
        do_start(1'b0);
        run_load(3, 1'b1, 1'b0, 1'b0);

        // Gapped five-word image.
        do_start(1'b0);
        run_load(5, 1'b1, 1'b1, 1'b0);

        // Restart from RUN with a two-word image.
        do_start(1'b0);
        run_load(2, 1'b1, 1'b0, 1'b0);

        // No ld_last: truncation at full depth, later words refused.
        do_start(1'b0);
        run_load(10, 1'b0, 1'b0, 1'b0);

        // Mid-load restart with a word offered in the restart cycle.
        do_start(1'b0);
        run_load(2, 1'b0, 1'b0, 1'b0);
        do_start(1'b1);
        run_load(3, 1'b1, 1'b0, 1'b0);

`ifdef CHECKSUM_EN
        do_start(1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b0);
        send_word(32'd6, 1'b1);
        check_end();
        do_start(1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b0);
        send_word(32'd7, 1'b1);
        check_end();
        do_start(1'b0);
        chk("err_cleared", 64'(boot_err), 64'd0);
        run_load(2, 1'b1, 1'b0, 1'b0);
`endif

        // Random loads, some left unfinished and restarted mid-stream.
        for (int it = 0; it < 24; it++) begin
            do_start(m_loading);
            partial = ($urandom_range(0, 3) == 0);
            if (partial) begin
                n = $urandom_range(1, DEPTH - 1);
                run_load(n, 1'b0, 1'(($urandom_range(0, 1))), 1'b0);
            end else begin
                n = $urandom_range(1, DEPTH + 2);
                run_load(n, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 2) == 0));
            end
        end

        idle(4);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
